pixel_write_buffer: RTL and testbench
=====================================

PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, at least 4.
REQ-002 Parameter SCREEN_W, default 320, visible columns.
REQ-003 Parameter SCREEN_H, default 240, visible rows.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 X_in  input  9  pixel column from the game view stage.
REQ-007 Y_in  input  8  pixel row.
REQ-008 Color_in  input  12  RGB444 pixel colour.
REQ-009 writeEn_in  input  1  pixel valid strobe.
REQ-010 in_ready  output  1  buffer can accept a pixel this cycle.
REQ-011 mem_addr  output  17  framebuffer word address.
REQ-012 mem_data  output  12  framebuffer write data.
REQ-013 mem_wren  output  1  write request to the framebuffer port.
REQ-014 mem_ready  input  1  framebuffer accepts the write this cycle.
REQ-015 clear_status  input  1  synchronous clear of overflow and drop_count.
REQ-016 overflow  output  1  sticky: a pixel was offered while in_ready was low.
REQ-017 drop_count  output  8  saturating count of out-of-range pixels.
REQ-018 idle  output  1  no pixel staged or buffered.

Function
REQ-019 Accept on a rising edge when writeEn_in and in_ready are both high; no other input condition causes acceptance.
REQ-020 in_ready = (fifo_count + stage_valid) < DEPTH; derived from registers only, with no combinational path from mem_ready.
REQ-021 Offer while in_ready is low: discard the pixel, set overflow, leave all other state unchanged.
REQ-022 Stage 1 register: on acceptance, capture color and address = Y_in*SCREEN_W + X_in, computed as (Y<<8)+(Y<<6)+X for the default width, 17-bit, no truncation.
REQ-023 Range check: X_in >= SCREEN_W or Y_in >= SCREEN_H means the pixel never enters the FIFO, and drop_count increments, saturating at 255.
REQ-024 Stage 2: a valid stage register is written into the FIFO on the next edge.
REQ-025 Latency: pixel accepted at edge E0, mem_wren high in the cycle after edge E1 when the FIFO was empty, i.e. 2 edges.
REQ-026 mem_wren = FIFO not empty; mem_addr and mem_data present the head entry and hold stable while mem_wren is high and mem_ready is low.
REQ-027 Pop when mem_wren and mem_ready are both high; the next entry is presented in the following cycle.
REQ-028 Simultaneous push and pop: both happen, and the count is unchanged.
REQ-029 Pointers wrap modulo DEPTH.
REQ-030 Pixel write order to the memory port matches acceptance order exactly.
REQ-031 Colour 0 is not filtered here; it is written like any other colour.
REQ-032 idle = FIFO empty and stage_valid low.
REQ-033 clear_status and overflow set in the same cycle: set wins. clear_status and a drop in the same cycle: drop_count becomes 1.

Reset
REQ-034 resetn low asynchronously empties the FIFO, clears stage_valid, and sets mem_wren=0, overflow=0, drop_count=0, idle=1, in_ready=1.
REQ-035 mem_addr and mem_data reset to 0.
REQ-036 Reset mid-burst discards all buffered pixels; no partial write is issued after release.

Structure
REQ-037 A shared package holds SCREEN_W, SCREEN_H, COLOR_W=12, X_W=9, Y_W=8, ADDR_W=17.
REQ-038 Storage is one sub-module, sync_fifo (parameterised width and depth, registered count, async active-low reset); the address stage, range check and status counters live in the top.

Verification
REQ-039 Single pixel (X=10, Y=2, Color=0xF00) with mem_ready=1 -> one write, mem_addr=650, mem_data=0xF00, 2 edges after acceptance; idle returns to 1.
REQ-040 Corner pixel (319,239) -> mem_addr=76799. Pixel (320,0) -> no write, drop_count=1.
REQ-041 mem_ready=0, writeEn_in held high for 20 cycles -> exactly DEPTH=16 accepted, in_ready falls, overflow=1. Then mem_ready=1 -> 16 writes in acceptance order.
REQ-042 Continuous input with mem_ready toggling 1/0 -> no loss, no duplicates, order preserved, and mem_addr/mem_data stable during every stall cycle.
REQ-043 300 out-of-range pixels -> drop_count saturates at 255. clear_status pulse -> 0.
REQ-044 resetn asserted with 8 entries buffered -> mem_wren=0 immediately; after release, no stale writes are issued.

Source files
------------

// File: rtl/pixel_write_buffer_pkg.sv
// Shared geometry, widths and the pixel entry layout for the pixel write buffer.
package pixel_write_buffer_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned COLOR_W  = 12;
    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned ADDR_W   = 17;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pixel_entry_t;

    localparam int unsigned ENTRY_W = $bits(pixel_entry_t);

    // Row-major framebuffer address; the 320-wide case avoids a multiplier.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y,
                                                     input int unsigned    width);
        logic [ADDR_W-1:0] x_ext;
        logic [ADDR_W-1:0] y_ext;
        x_ext = ADDR_W'(x);
        y_ext = ADDR_W'(y);
        if (width == 320) begin
            return (y_ext << 8) + (y_ext << 6) + x_ext;
        end
        return ADDR_W'(32'(y) * width + 32'(x));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (32'(count_q) < DEPTH);
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers pixel writes from the game view stage: address stage, range check, FIFO to the
// framebuffer port, plus sticky overflow and saturating drop counter.
module pixel_write_buffer
    import pixel_write_buffer_pkg::X_W, pixel_write_buffer_pkg::Y_W,
           pixel_write_buffer_pkg::COLOR_W, pixel_write_buffer_pkg::ADDR_W,
           pixel_write_buffer_pkg::ENTRY_W, pixel_write_buffer_pkg::pixel_entry_t,
           pixel_write_buffer_pkg::pixel_addr;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = pixel_write_buffer_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = pixel_write_buffer_pkg::SCREEN_H
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [X_W-1:0]     X_in,
    input  logic [Y_W-1:0]     Y_in,
    input  logic [COLOR_W-1:0] Color_in,
    input  logic               writeEn_in,
    output logic               in_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_wren,
    input  logic               mem_ready,
    input  logic               clear_status,
    output logic               overflow,
    output logic [7:0]         drop_count,
    output logic               idle
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic         stage_valid_q;
    logic         stage_valid_d;
    pixel_entry_t stage_q;
    pixel_entry_t stage_d;
    logic         overflow_q;
    logic         overflow_d;
    logic [7:0]   drop_q;
    logic [7:0]   drop_d;

    logic             accept;
    logic             in_range;
    logic             drop;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    pixel_entry_t     head;

    // Counts the staged pixel too, so a push from the stage always finds room.
    assign in_ready = (32'(fifo_count) + 32'(stage_valid_q)) < DEPTH;
    assign accept   = writeEn_in && in_ready;
    assign in_range = (32'(X_in) < SCREEN_W) && (32'(Y_in) < SCREEN_H);
    assign drop     = accept && !in_range;

    always_comb begin
        stage_valid_d = accept && in_range;
        stage_d       = stage_q;
        if (accept && in_range) begin
            stage_d.addr  = pixel_addr(X_in, Y_in, SCREEN_W);
            stage_d.color = Color_in;
        end

        overflow_d = overflow_q;
        if (writeEn_in && !in_ready) begin
            overflow_d = 1'b1;
        end else if (clear_status) begin
            overflow_d = 1'b0;
        end

        drop_d = drop_q;
        if (drop) begin
            if (clear_status) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (clear_status) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            overflow_q    <= 1'b0;
            drop_q        <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
            overflow_q    <= overflow_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (stage_valid_q),
        .wdata  (stage_q),
        .pop    (fifo_pop),
        .rdata  (head),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign fifo_pop = !fifo_empty && mem_ready;

    // Head is masked while empty so the port reads zero out of reset and between bursts.
    assign mem_wren   = !fifo_empty;
    assign mem_addr   = fifo_empty ? '0 : head.addr;
    assign mem_data   = fifo_empty ? '0 : head.color;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign idle       = fifo_empty && !stage_valid_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed + randomized bench for pixel_write_buffer against a queue-based reference model.
module tb_pixel_write_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [8:0]  X_in;
    logic [7:0]  Y_in;
    logic [11:0] Color_in;
    logic        writeEn_in;
    logic        in_ready;
    logic [16:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_wren;
    logic        mem_ready;
    logic        clear_status;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected writes in acceptance order, observed writes, status.
    logic [28:0] exp_q[$];
    logic [28:0] obs_q[$];
    logic        m_ovf;
    int          m_drop;

    int          stall_bad = 0;
    logic        prev_stall;
    logic [16:0] prev_addr;
    logic [11:0] prev_data;

    always #5 clk = ~clk;

    pixel_write_buffer dut (
        .clk          (clk),
        .resetn       (resetn),
        .X_in         (X_in),
        .Y_in         (Y_in),
        .Color_in     (Color_in),
        .writeEn_in   (writeEn_in),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_ready    (mem_ready),
        .clear_status (clear_status),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .idle         (idle)
    );

    // Records completed writes and checks the head holds while stalled.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_stall <= 1'b0;
        end else begin
            if (mem_wren && mem_ready) obs_q.push_back({mem_addr, mem_data});
            if (prev_stall && (!mem_wren || mem_addr !== prev_addr || mem_data !== prev_data))
                stall_bad <= stall_bad + 1;
            prev_stall <= mem_wren && !mem_ready;
            prev_addr  <= mem_addr;
            prev_data  <= mem_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic pred_ready();
        return (exp_q.size() - obs_q.size()) < DEPTH;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // One clock: offer inputs, update the model, advance to 1 time unit after the edge.
    task automatic cycle(input logic we, input int x, input int y, input int c,
                         input logic rdy, input logic clr);
        logic rdy_p;
        logic drop_ev;
        rdy_p = pred_ready();
        chk("in_ready", 32'(in_ready), 32'(rdy_p));
        writeEn_in   = we;
        X_in         = x[8:0];
        Y_in         = y[7:0];
        Color_in     = c[11:0];
        mem_ready    = rdy;
        clear_status = clr;
        drop_ev = 1'b0;
        if (we && rdy_p) begin
            if (x < 320 && y < 240) exp_q.push_back({17'(y * 320 + x), 12'(c)});
            else drop_ev = 1'b1;
        end
        if (drop_ev) m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
        else if (clr) m_drop = 0;
        if (we && !rdy_p) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        writeEn_in   = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 200) begin
            cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
            n++;
        end
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_entry"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_idle"}, 32'(idle), 32'd1);
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        resetn       = 1'b0;
        writeEn_in   = 1'b0;
        X_in         = '0;
        Y_in         = '0;
        Color_in     = '0;
        mem_ready    = 1'b0;
        clear_status = 1'b0;
        model_reset();
        #1;
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel, two-edge latency.
        cycle(1'b1, 10, 2, 'hF00, 1'b1, 1'b0);
        chk("lat_e0_wren", 32'(mem_wren), 32'd0);
        chk("lat_e0_idle", 32'(idle), 32'd0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("lat_e1_wren", 32'(mem_wren), 32'd1);
        chk("lat_e1_addr", 32'(mem_addr), 32'd650);
        chk("lat_e1_data", 32'(mem_data), 32'hF00);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("single_writes", 32'(obs_q.size()), 32'd1);
        drain("single");

        // Corner pixel with colour 0, then out-of-range column.
        cycle(1'b1, 319, 239, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("corner_addr", 32'(mem_addr), 32'd76799);
        drain("corner");
        cycle(1'b1, 320, 0, 'h123, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("drop_one", 32'(drop_count), 32'd1);
        chk("drop_no_wren", 32'(mem_wren), 32'd0);
        drain("drop");

        // Drop coinciding with clear leaves a count of one.
        cycle(1'b1, 0, 240, 1, 1'b1, 1'b0);
        cycle(1'b1, 400, 5, 1, 1'b1, 1'b1);
        chk("drop_clear_same", 32'(drop_count), 32'd1);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        chk_status("clear");

        // Stalled port, 20 offers: DEPTH accepted, then overflow.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, rnd(0, 319), rnd(0, 239), rnd(0, 4095), 1'b0, 1'b0);
        chk("burst_in_ready", 32'(in_ready), 32'd0);
        chk("burst_overflow", 32'(overflow), 32'd1);
        chk("burst_wren", 32'(mem_wren), 32'd1);
        cycle(1'b1, 5, 5, 5, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        drain("burst");

        // Streaming with toggling, then random, backpressure.
        for (int i = 0; i < 300; i++) begin
            logic we;
            logic rdy;
            int   x;
            int   y;
            we  = (rnd(0, 7) != 0);
            rdy = (i < 150) ? (i % 2 == 0) : (rnd(0, 2) != 0);
            x   = rnd(0, 319);
            y   = rnd(0, 239);
            if (rnd(0, 15) == 0) x = rnd(320, 511);
            if (rnd(0, 15) == 0) y = rnd(240, 255);
            cycle(we, x, y, rnd(0, 4095), rdy, 1'b0);
        end
        chk_status("stream");
        drain("stream");
        chk("stall_stable", 32'(stall_bad), 32'd0);

        // Drop counter saturation and clear.
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++)
            cycle(1'b1, rnd(320, 511), rnd(0, 255), rnd(0, 4095), 1'b1, 1'b0);
        chk("drop_sat", 32'(drop_count), 32'd255);
        chk_status("sat");
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        chk("drop_sat_clear", 32'(drop_count), 32'd0);

        // Reset with eight pixels buffered.
        for (int i = 0; i < 8; i++)
            cycle(1'b1, rnd(0, 319), rnd(0, 239), rnd(0, 4095), 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("pre_rst_wren", 32'(mem_wren), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(mem_wren), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("no_stale_writes", 32'(obs_q.size()), 32'd0);
        chk("post_rst_wren", 32'(mem_wren), 32'd0);

        cycle(1'b1, 100, 50, 'hABC, 1'b1, 1'b0);
        drain("post_reset");
        chk_status("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
